// File: rtl/dda_ray_engine_if.sv
// dda_ray_engine_if: ray request, map RAM port and result bundle for dda_ray_engine
//   master: ray requester / map RAM / result consumer side
//   slave : the engine
//   in_valid/in_ready + x_pos, y_pos, ray_dir_x, ray_dir_y, delta_x, delta_y : ray request
//   map_addr -> / map_data <- : {mapY, mapX} lookup, data one cycle after address
//   out_valid/out_ready + color, side, hit, perp_dist, height : result
interface dda_ray_engine_if #(
  parameter int MAP_BITS = 6
);
  logic                    in_valid;
  logic                    in_ready;
  logic [15:0]             x_pos;
  logic [15:0]             y_pos;
  logic [15:0]             ray_dir_x;
  logic [15:0]             ray_dir_y;
  logic [15:0]             delta_x;
  logic [15:0]             delta_y;
  logic [2*MAP_BITS-1:0]   map_addr;
  logic [7:0]              map_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [7:0]              color;
  logic                    side;
  logic                    hit;
  logic [15:0]             perp_dist;
  logic [9:0]              height;
  modport master (
    output in_valid, x_pos, y_pos, ray_dir_x, ray_dir_y, delta_x, delta_y, map_data, out_ready,
    input  in_ready, map_addr, out_valid, color, side, hit, perp_dist, height
  );
  modport slave (
    input  in_valid, x_pos, y_pos, ray_dir_x, ray_dir_y, delta_x, delta_y, map_data, out_ready,
    output in_ready, map_addr, out_valid, color, side, hit, perp_dist, height
  );
endinterface

// File: rtl/dda_ray_engine.sv
// dda_ray_engine: grid DDA ray caster returning wall hit, side, colour, distance and column height
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : dda_ray_engine_if.slave (ray request, map RAM port, result handshake)
//   DDA_HEIGHT_DIV_EN defined builds the 16-cycle height divider; undefined ties height to 0
module dda_ray_engine #(
  parameter int SCREEN_HEIGHT = 600,
  parameter int MAP_BITS      = 6,
  parameter int MAX_STEPS     = 64
) (
  input logic clk,
  input logic rst,
  dda_ray_engine_if.slave bus
);
  localparam int MB = MAP_BITS;
  typedef enum logic [2:0] {IDLE, INIT, STEP, WAIT, CHECK, DIV, DONE} state_t;
  state_t state_q;
  logic [15:0] x_pos_q, y_pos_q, delta_x_q, delta_y_q;
  logic [15:0] side_dist_x_q, side_dist_y_q, perp_dist_q, steps_q;
  logic neg_x_q, neg_y_q, side_q, hit_q, in_ready_q, out_valid_q;
  logic [MB:0] map_x_q, map_y_q;
  logic [2*MB-1:0] map_addr_q;
  logic [7:0] color_q;
  logic [9:0] height_q;
  logic [24:0] prod_x, prod_y;
  logic [16:0] sum_x, sum_y;
  logic [MB:0] map_x_d, map_y_d;
  logic [15:0] side_dist_x_d, side_dist_y_d, perp_d;
  logic step_y, start_out, outside, hit_c, finish;
  // cell coordinates carry one extra bit: stepping past either map edge sets it
  always_comb begin
    prod_x = (neg_x_q ? {17'd0, x_pos_q[7:0]} : 25'd256 - {17'd0, x_pos_q[7:0]}) * {9'd0, delta_x_q};
    prod_y = (neg_y_q ? {17'd0, y_pos_q[7:0]} : 25'd256 - {17'd0, y_pos_q[7:0]}) * {9'd0, delta_y_q};
    step_y = side_dist_y_q <= side_dist_x_q;
    sum_x = {1'b0, side_dist_x_q} + {1'b0, delta_x_q};
    sum_y = {1'b0, side_dist_y_q} + {1'b0, delta_y_q};
    map_x_d = step_y ? map_x_q : neg_x_q ? map_x_q - 1'b1 : map_x_q + 1'b1;
    map_y_d = !step_y ? map_y_q : neg_y_q ? map_y_q - 1'b1 : map_y_q + 1'b1;
    side_dist_x_d = step_y ? side_dist_x_q : sum_x[16] ? 16'hFFFF : sum_x[15:0];
    side_dist_y_d = !step_y ? side_dist_y_q : sum_y[16] ? 16'hFFFF : sum_y[15:0];
    perp_d = steps_q == 16'd0 ? 16'd0 : side_q ? side_dist_y_q - delta_y_q : side_dist_x_q - delta_x_q;
    start_out = |(x_pos_q >> (8 + MB)) || |(y_pos_q >> (8 + MB));
    outside = map_x_q[MB] | map_y_q[MB];
    hit_c = state_q == CHECK && !outside && |bus.map_data;
    finish = (state_q == INIT && start_out) ||
             (state_q == CHECK && (outside || hit_c || steps_q == 16'(MAX_STEPS)));
  end
`ifdef DDA_HEIGHT_DIV_EN
  // SCREEN_HEIGHT*256 / perp_dist; the upper dividend half seeds the remainder, which is
  // exact whenever perp_dist >= 256 (smaller distances clamp to SCREEN_HEIGHT anyway)
  localparam logic [31:0] DIV_NUM = 32'(SCREEN_HEIGHT * 256);
  localparam logic [15:0] DIV_HI = DIV_NUM[31:16];
  localparam logic [15:0] DIV_LO = DIV_NUM[15:0];
  localparam logic [9:0] SH = 10'(SCREEN_HEIGHT);
  logic [15:0] rem_q, quo_q, quo_d, div_s;
  logic [3:0] div_cnt_q;
  logic [16:0] div_r;
  logic div_ge;
  always_comb begin
    div_r = {rem_q, DIV_LO[~div_cnt_q]};
    div_ge = div_r >= {1'b0, perp_dist_q};
    div_s = div_r[15:0] - perp_dist_q;
    quo_d = {quo_q[14:0], div_ge};
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      color_q <= '0;
      side_q <= 1'b0;
      hit_q <= 1'b0;
      perp_dist_q <= '0;
      height_q <= '0;
      map_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          state_q <= INIT;
          in_ready_q <= 1'b0;
          x_pos_q <= bus.x_pos;
          y_pos_q <= bus.y_pos;
          neg_x_q <= bus.ray_dir_x[15];
          neg_y_q <= bus.ray_dir_y[15];
          delta_x_q <= bus.delta_x;
          delta_y_q <= bus.delta_y;
          steps_q <= '0;
          height_q <= '0;
        end
        INIT: begin
          state_q <= STEP;
          map_x_q <= {1'b0, x_pos_q[8+MB-1:8]};
          map_y_q <= {1'b0, y_pos_q[8+MB-1:8]};
          side_dist_x_q <= prod_x[23:8];
          side_dist_y_q <= prod_y[23:8];
          side_q <= 1'b0;
        end
        STEP: begin
          state_q <= WAIT;
          map_x_q <= map_x_d;
          map_y_q <= map_y_d;
          side_dist_x_q <= side_dist_x_d;
          side_dist_y_q <= side_dist_y_d;
          side_q <= step_y;
          steps_q <= steps_q + 16'd1;
          map_addr_q <= {map_y_d[MB-1:0], map_x_d[MB-1:0]};
        end
        WAIT: state_q <= CHECK;
        CHECK: state_q <= STEP;
`ifdef DDA_HEIGHT_DIV_EN
        DIV: begin
          rem_q <= div_ge ? div_s : div_r[15:0];
          quo_q <= quo_d;
          div_cnt_q <= div_cnt_q + 4'd1;
          if (&div_cnt_q) begin
            state_q <= DONE;
            out_valid_q <= 1'b1;
            height_q <= !hit_q ? 10'd0 : ~|perp_dist_q[15:8] ? SH : quo_d > {6'd0, SH} ? SH : quo_d[9:0];
          end
        end
`endif
        DONE: if (bus.out_ready) begin
          state_q <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
      // ray finished (start cell off-map, wall, map exit or step budget): latch result
      if (finish) begin
        hit_q <= hit_c;
        color_q <= hit_c ? bus.map_data : 8'd0;
        perp_dist_q <= perp_d;
`ifdef DDA_HEIGHT_DIV_EN
        state_q <= DIV;
        rem_q <= DIV_HI;
        quo_q <= '0;
        div_cnt_q <= '0;
`else
        state_q <= DONE;
        out_valid_q <= 1'b1;
`endif
      end
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.map_addr = map_addr_q;
  assign bus.color = color_q;
  assign bus.side = side_q;
  assign bus.hit = hit_q;
  assign bus.perp_dist = perp_dist_q;
  assign bus.height = height_q;
endmodule

// File: doc/dda_ray_engine.md
DDA_RAY_ENGINE -- requirements
Module: dda_ray_engine

Interface
REQ-001 SCREEN_HEIGHT, 600, screen height in pixels; height output ceiling.
REQ-002 MAP_BITS, 6, map is 2^MAP_BITS x 2^MAP_BITS cells.
REQ-003 MAX_STEPS, 64, DDA steps allowed before the ray is declared a miss.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid / in_ready  in/out  1/1  ray request handshake.
REQ-007 x_pos, y_pos  in  16/16  player position, Q8.8 map units.
REQ-008 ray_dir_x, ray_dir_y  in  16/16  signed Q2.14 ray direction.
REQ-009 delta_x, delta_y  in  16/16  unsigned Q8.8 |1/ray_dir|; 16'hFFFF when that component is 0.
REQ-010 map_addr  out  2*MAP_BITS  {mapY, mapX} cell address to external map RAM.
REQ-011 map_data  in  8  cell contents; valid the cycle after map_addr is presented; nonzero = wall.
REQ-012 out_valid / out_ready  out/in  1/1  result handshake.
REQ-013 color  out  8  map_data of hit cell; 0 on miss.
REQ-014 side  out  1  0 = X wall, 1 = Y wall.
REQ-015 hit  out  1  1 = wall hit, 0 = miss.
REQ-016 perp_dist  out  16  Q8.8 perpendicular wall distance.
REQ-017 height  out  10  wall column height in pixels.

Function
REQ-018 FSM states IDLE, INIT, STEP, WAIT, CHECK, DIV, DONE; in_ready = 1 only in IDLE; one ray in flight.
REQ-019 IDLE->INIT on in_valid&&in_ready; inputs captured on that edge.
REQ-020 INIT: cell = pos[8+MAP_BITS-1:8]; frac = pos[7:0]; side_dist = (frac*delta)>>8 if dir negative, else ((256-frac)*delta)>>8; step = -1 if dir negative, else +1.
REQ-021 STEP: if side_dist_x < side_dist_y, advance X (side=0), else advance Y (side=1); ties step Y; side_dist += delta, saturating at 16'hFFFF.
REQ-022 STEP->WAIT->CHECK; map_addr registered on the STEP exit edge; map_data sampled in CHECK; 3 cycles per step.
REQ-023 CHECK: map_data != 0 -> hit=1, DIV; step count == MAX_STEPS or cell stepped outside 0..2^MAP_BITS-1 -> hit=0, DIV; else STEP.
REQ-024 Starting cell with pos[15:8+MAP_BITS] != 0 -> miss, INIT goes straight to DIV.
REQ-025 perp_dist = side_dist - delta of the last stepped axis; 0 when no step taken.
REQ-026 DIV: 16-cycle restoring divide; height = min(SCREEN_HEIGHT, SCREEN_HEIGHT*256/perp_dist); perp_dist 0 -> SCREEN_HEIGHT; miss -> 0.
REQ-027 Latency: for a result after N steps, out_valid rises 3N+17 edges after the accepting edge.
REQ-028 DONE: out_valid held with all result outputs stable until out_ready; on out_valid&&out_ready go to IDLE, out_valid low next cycle.

Reset
REQ-029 rst -> state IDLE; out_valid, color, side, hit, perp_dist, height, map_addr all 0; in_ready 1 the first cycle after rst deasserts.
REQ-030 rst mid-ray aborts without producing out_valid; rst has priority over all handshakes.

Configuration
REQ-031 Macro DDA_HEIGHT_DIV_EN defined: DIV state and divider built as in REQ-026.
REQ-032 Undefined: no divider, DIV skipped, height tied to 0, latency 3N+1.

Verification
REQ-033 pos (0x0280,0x0280), dir (0x4000,0), delta (0x0100,0xFFFF), wall value 7 at cell (5,2) -> hit=1, side=0, color=7, perp_dist=0x0280, height=240, out_valid 26 edges after accept.
REQ-034 pos (0x0280,0x0280), dir (0x2D41,0x2D41), delta (0x016A,0x016A), wall at (2,3) -> first step is Y (tie rule), hit=1, side=1, color = wall value.
REQ-035 Empty map, dir +X from cell (62,2) -> exits map after 2 steps: hit=0, color=0, height=0.
REQ-036 Empty 1024-cell map with MAX_STEPS=4 -> miss after exactly 4 steps, out_valid 29 edges after accept.
REQ-037 out_ready low for 5 cycles in DONE -> outputs stable, in_ready=0 throughout; handshake completes on first out_ready cycle.
REQ-038 rst pulse during WAIT -> out_valid never asserts, all outputs 0, next ray accepted and completes normally.
